coin_input_conditioner: RTL and testbench



---
 rtl/coin_pkg.sv | 24 ++
 rtl/sync_debounce.sv | 59 +++++
 rtl/coin_input_conditioner.sv | 99 +++++++++
 tb/tb_coin_input_conditioner.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Coin codes and conditioner state encodings shared with the vending credit FSM.
// Coin codes are the raw coin_sel switch values latched at press acceptance.
package coin_pkg;

   localparam logic [1:0] COIN_NONE  = 2'b00;
   localparam logic [1:0] COIN_25C   = 2'b01;
   localparam logic [1:0] COIN_50C   = 2'b10;
   localparam logic [1:0] COIN_1BIRR = 2'b11;

   localparam int SYNC_STAGES = 2;
   localparam logic [7:0] COUNT_MAX = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HOLD  = 2'd2
   } coin_state_t;

   // A press with coin_sel at COIN_NONE is consumed without producing a token.
   function automatic logic is_coin(input logic [1:0] code);
      return code != COIN_NONE;
   endfunction

endpackage

// File: rtl/sync_debounce.sv
// Synchroniser plus stability counter for an active-low pushbutton.
// level is the accepted (debounced) level; press/release_evt pulse in the cycle it flips.
module sync_debounce
   import coin_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic srst,
   input  logic raw_n,
   output logic level,
   output logic press_evt,
   output logic release_evt
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   level_reg;
   logic [CNT_W-1:0]       cnt_reg;
   logic                   synced;
   logic                   flip;

   // Stages preset high so a released button is never mistaken for a press.
   generate
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         always_ff @(posedge clk) begin
            if (srst) begin
               sync_reg[gi] <= 1'b1;
            end else if (gi == 0) begin
               sync_reg[gi] <= raw_n;
            end else begin
               sync_reg[gi] <= sync_reg[(gi > 0) ? gi - 1 : 0];
            end
         end
      end
   endgenerate

   assign synced = sync_reg[SYNC_STAGES-1];
   assign flip   = (synced != level_reg) && (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (srst) begin
         level_reg <= 1'b1;
         cnt_reg   <= '0;
      end else if (synced == level_reg) begin
         cnt_reg   <= '0;
      end else if (flip) begin
         level_reg <= synced;
         cnt_reg   <= '0;
      end else begin
         cnt_reg   <= cnt_reg + CNT_W'(1);
      end
   end

   assign level       = level_reg;
   assign press_evt   = flip & level_reg;
   assign release_evt = flip & ~level_reg;

endmodule

// File: rtl/coin_input_conditioner.sv
// Turns a debounced insert press plus coin_sel into one valid/ready coin token.
// Define COIN_INPUT_CONDITIONER_COUNT_EN to build the saturating accepted-coin counter.
module coin_input_conditioner
   import coin_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [1:0] coin_sel,
   input  logic       insert_n,
   input  logic       coin_ready,
   output logic       coin_valid,
   output logic [1:0] coin_code,
   output logic       busy,
   output logic [7:0] coin_count
);

   coin_state_t state_reg, state_next;
   logic [1:0]  code_reg, code_next;
   logic        level;
   logic        press_evt;
   logic        release_evt;
   logic        transfer;

   sync_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_debounce (
      .clk         (CLOCK_50),
      .srst        (reset),
      .raw_n       (insert_n),
      .level       (level),
      .press_evt   (press_evt),
      .release_evt (release_evt)
   );

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         code_reg  <= COIN_NONE;
      end else begin
         state_reg <= state_next;
         code_reg  <= code_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      code_next  = code_reg;
      case (state_reg)
         ST_IDLE: begin
            if (press_evt) begin
               code_next  = coin_sel;
               state_next = is_coin(coin_sel) ? ST_ISSUE : ST_HOLD;
            end
         end
         ST_ISSUE: begin
            if (coin_ready) begin
               state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // A release seen while the token was pending is already in level.
            if (level || release_evt) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign coin_valid = (state_reg == ST_ISSUE);
   assign coin_code  = code_reg;
   assign busy       = (state_reg != ST_IDLE);
   assign transfer   = coin_valid & coin_ready;

`ifdef COIN_INPUT_CONDITIONER_COUNT_EN
   logic [7:0] count_reg;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         count_reg <= 8'd0;
      end else if (transfer && (count_reg != COUNT_MAX)) begin
         count_reg <= count_reg + 8'd1;
      end
   end

   assign coin_count = count_reg;
`else
   logic unused_transfer;
   assign unused_transfer = transfer;
   assign coin_count      = 8'd0;
`endif

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Self-checking bench for coin_input_conditioner with DEBOUNCE_CYCLES=4, CNT_W=3:
// directed table, hand sequences, then random presses against a behavioural model.
module tb_coin_input_conditioner;

   localparam int DC = 4;
   localparam int CW = 3;

   logic       CLOCK_50 = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] coin_sel = 2'b00;
   logic       insert_n = 1'b1;
   logic       coin_ready = 1'b0;
   logic       coin_valid;
   logic [1:0] coin_code;
   logic       busy;
   logic [7:0] coin_count;

   int n_checks = 0;
   int n_fail = 0;

   coin_input_conditioner #(
      .DEBOUNCE_CYCLES (DC),
      .CNT_W           (CW)
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .coin_sel   (coin_sel),
      .insert_n   (insert_n),
      .coin_ready (coin_ready),
      .coin_valid (coin_valid),
      .coin_code  (coin_code),
      .busy       (busy),
      .coin_count (coin_count)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The button is accepted as changed once DC consecutive synchronised samples
   // (each two clocks old) disagree with the accepted level.
   bit         model_on = 0;
   bit         rawq[$];
   bit         synq[$];
   bit         m_level;
   bit         m_token;
   bit         m_wait;
   logic [1:0] m_code;
   int         m_count;

   function automatic void model_reset();
      rawq = '{1'b1, 1'b1};
      synq.delete();
      m_level = 1'b1;
      m_token = 1'b0;
      m_wait  = 1'b0;
      m_code  = 2'b00;
      m_count = 0;
   endfunction

   function automatic void model_step();
      bit v, old_level, press, rel, all_diff;
      if (reset) begin
         model_reset();
         return;
      end
      v = rawq.pop_front();
      rawq.push_back(insert_n);
      synq.push_back(v);
      if (synq.size() > DC) void'(synq.pop_front());
      all_diff = (synq.size() == DC);
      foreach (synq[i]) if (synq[i] == m_level) all_diff = 1'b0;
      old_level = m_level;
      press = 1'b0;
      rel   = 1'b0;
      if (all_diff) begin
         m_level = !m_level;
         press   = !m_level;
         rel     = m_level;
         synq.delete();
      end
      if (m_token) begin
         if (coin_ready) begin
            m_token = 1'b0;
            m_wait  = 1'b1;
            if (m_count < 255) m_count++;
         end
      end else if (m_wait) begin
         if (old_level || rel) m_wait = 1'b0;
      end else if (press) begin
         m_code = coin_sel;
         if (coin_sel != 2'b00) m_token = 1'b1;
         else m_wait = 1'b1;
      end
   endfunction

   task automatic model_compare();
      check("m_valid", coin_valid, m_token);
      check("m_busy", busy, m_token | m_wait);
      if (m_token) check("m_code", coin_code, m_code);
`ifdef COIN_INPUT_CONDITIONER_COUNT_EN
      check("m_count", coin_count, m_count);
`else
      check("m_count", coin_count, 0);
`endif
   endtask

   // One clock: inputs were set before the posedge, outputs sampled on the negedge.
   task automatic cycle();
      @(negedge CLOCK_50);
      if (model_on) begin
         model_step();
         model_compare();
      end
   endtask

   task automatic rcycle();
      coin_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) coin_sel = 2'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      cycle();
      reset = 1'b0;
   endtask

   typedef struct {
      logic [1:0] sel;
      int         rdy_wait;
      int         exp_rise;
      int         exp_valid_cycles;
      logic [1:0] exp_code;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int rise, nvalid, code_ok, got;

      vecs[0] = '{2'b01, 0,  6, 1,  2'b01};
      vecs[1] = '{2'b11, 10, 6, 11, 2'b11};
      vecs[2] = '{2'b00, 0,  0, 0,  2'b00};
      vecs[3] = '{2'b10, 3,  6, 4,  2'b10};

      // Reset state
      reset = 1'b1;
      repeat (3) cycle();
      check("rst_valid", coin_valid, 0);
      check("rst_code", coin_code, 0);
      check("rst_busy", busy, 0);
      check("rst_count", coin_count, 0);
      reset = 1'b0;
      repeat (4) cycle();

      // Directed table: press held 24 cycles, then release
      foreach (vecs[i]) begin
         coin_sel   = vecs[i].sel;
         coin_ready = (vecs[i].rdy_wait == 0);
         insert_n   = 1'b0;
         rise = 0; nvalid = 0; code_ok = 1;
         for (int k = 1; k <= 24; k++) begin
            cycle();
            if (coin_valid) begin
               if (rise == 0) rise = k;
               nvalid++;
               if (coin_code !== vecs[i].exp_code) code_ok = 0;
               if (vecs[i].rdy_wait > 0 && nvalid == vecs[i].rdy_wait + 1) coin_ready = 1'b1;
            end
            if (k == 8) coin_sel = 2'b01;
         end
         if (vecs[i].exp_rise != 0) check($sformatf("v%0d_rise", i), rise, vecs[i].exp_rise);
         check($sformatf("v%0d_nvalid", i), nvalid, vecs[i].exp_valid_cycles);
         check($sformatf("v%0d_code_stable", i), code_ok, 1);
         check($sformatf("v%0d_busy_held", i), busy, 1);
         insert_n   = 1'b1;
         coin_ready = 1'b0;
         for (int k = 1; k <= 6; k++) begin
            cycle();
            if (k == 5) check($sformatf("v%0d_busy_rel5", i), busy, 1);
            if (k == 6) check($sformatf("v%0d_busy_rel6", i), busy, 0);
         end
         repeat (4) cycle();
      end

      // Bouncy press: three single-cycle lows before the real fall
      coin_sel = 2'b10;
      coin_ready = 1'b1;
      for (int b = 0; b < 3; b++) begin
         insert_n = 1'b0; cycle();
         insert_n = 1'b1; cycle();
      end
      insert_n = 1'b0;
      rise = 0; nvalid = 0;
      for (int k = 1; k <= 20; k++) begin
         cycle();
         if (coin_valid) begin
            if (rise == 0) rise = k;
            nvalid++;
         end
      end
      check("bounce_rise", rise, 6);
      check("bounce_nvalid", nvalid, 1);
      insert_n = 1'b1;
      repeat (10) cycle();
      check("bounce_idle", busy, 0);

      // Reset while a token is pending, button held through reset
      coin_sel = 2'b01;
      coin_ready = 1'b0;
      insert_n = 1'b0;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         cycle();
         if (coin_valid) got = 1;
      end
      check("rstmid_setup_valid", got, 1);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("rstmid_valid", coin_valid, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_count", coin_count, 0);
      coin_ready = 1'b1;
      rise = 0; nvalid = 0;
      for (int k = 1; k <= 14; k++) begin
         cycle();
         if (coin_valid) begin
            if (rise == 0) rise = k;
            nvalid++;
         end
      end
      check("rstmid_rise", rise, 6);
      check("rstmid_nvalid", nvalid, 1);
      insert_n = 1'b1;
      repeat (10) cycle();

      // Randomised presses with bounces, random ready and sel, occasional reset
      reset = 1'b1;
      model_on = 1;
      cycle();
      reset = 1'b0;
      for (int t = 0; t < 50; t++) begin
         int nb;
         coin_sel = 2'($urandom);
         nb = $urandom_range(0, 3);
         for (int b = 0; b < nb; b++) begin
            insert_n = 1'b0; rcycle();
            insert_n = 1'b1; rcycle();
         end
         insert_n = 1'b0;
         repeat ($urandom_range(3, 16)) rcycle();
         nb = $urandom_range(0, 3);
         for (int b = 0; b < nb; b++) begin
            insert_n = 1'b1; rcycle();
            insert_n = 1'b0; rcycle();
         end
         insert_n = 1'b1;
         repeat ($urandom_range(3, 14)) rcycle();
      end

      // Saturation: 300 accepted presses
      insert_n = 1'b1;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      coin_sel = 2'b01;
      coin_ready = 1'b1;
      for (int p = 0; p < 300; p++) begin
         insert_n = 1'b0;
         repeat (8) cycle();
         insert_n = 1'b1;
         repeat (8) cycle();
      end
`ifdef COIN_INPUT_CONDITIONER_COUNT_EN
      check("count_saturated", coin_count, 255);
`else
      check("count_tied_zero", coin_count, 0);
`endif
      model_on = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
